// File: rtl/fetch_branch_predictor.sv
// Fetch-stage jump predictor: a direct-mapped BTB with saturating direction counters,
// trained by resolved control flow from execute.
// Optional return-address stack is enabled by defining FETCH_BP_RAS_EN.

package fetch_bp_pkg;

    typedef enum logic [3:0] {
        OpNone   = 4'd0,
        OpAlu    = 4'd1,
        OpJr     = 4'd2,
        OpJalr   = 4'd3,
        OpBltz   = 4'd4,
        OpBltzal = 4'd5,
        OpBgez   = 4'd6,
        OpBgezal = 4'd7,
        OpJ      = 4'd8,
        OpJal    = 4'd9,
        OpBeq    = 4'd10,
        OpBne    = 4'd11,
        OpBlez   = 4'd12,
        OpBgtz   = 4'd13
    } op_t;

    typedef struct packed {
        logic        valid;
        logic        en;
        logic [31:0] pc_dst;
    } jmp_pack_t;

    function automatic logic is_cond(op_t op);
        return op inside {OpBltz, OpBltzal, OpBgez, OpBgezal, OpBeq, OpBne, OpBlez, OpBgtz};
    endfunction

    function automatic logic is_uncond(op_t op);
        return op inside {OpJ, OpJal, OpJr, OpJalr};
    endfunction

    function automatic logic is_call(op_t op);
        return op inside {OpJal, OpJalr};
    endfunction

endpackage

module fetch_branch_predictor
    import fetch_bp_pkg::*;
#(
    parameter int unsigned ENTRIES   = 64,
    parameter int unsigned CTR_BITS  = 2,
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        f_valid,
    input  logic [31:0] f_pc,
    input  op_t         f_op,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  op_t         ex_op,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        flush,
    output jmp_pack_t   jmp,
    output logic        hit
);

    localparam int unsigned IDX  = $clog2(ENTRIES);
    localparam int unsigned TAGW = 32 - IDX - 2;

    localparam logic [CTR_BITS-1:0] CtrMax  = '1;
    localparam logic [CTR_BITS-1:0] CtrWeak = CTR_BITS'(1) << (CTR_BITS - 1);

    logic                valid_q  [ENTRIES];
    logic [TAGW-1:0]     tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

    logic [IDX-1:0]  f_idx;
    logic [TAGW-1:0] f_tag;
    logic [IDX-1:0]  ex_idx;
    logic [TAGW-1:0] ex_tag;
    logic            ex_hit;

    logic                wr_en;
    logic [31:0]         wr_target;
    logic [CTR_BITS-1:0] wr_ctr;

    assign f_idx  = f_pc[IDX+1:2];
    assign f_tag  = f_pc[31:IDX+2];
    assign ex_idx = ex_pc[IDX+1:2];
    assign ex_tag = ex_pc[31:IDX+2];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

`ifdef FETCH_BP_RAS_EN
    localparam int unsigned RasPtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned RasCntW = $clog2(RAS_DEPTH + 1);

    logic [31:0]        ras_q [RAS_DEPTH];
    logic [RasPtrW-1:0] ras_ptr_q;   // next slot to write
    logic [RasCntW-1:0] ras_cnt_q;
    logic [RasPtrW-1:0] ras_ptr_inc;
    logic [RasPtrW-1:0] ras_ptr_dec;
    logic               ras_push;
    logic               ras_pop;

    assign ras_ptr_inc = (ras_ptr_q == RasPtrW'(RAS_DEPTH - 1)) ? '0 : ras_ptr_q + 1'b1;
    assign ras_ptr_dec = (ras_ptr_q == '0) ? RasPtrW'(RAS_DEPTH - 1) : ras_ptr_q - 1'b1;
    assign ras_push    = f_valid && is_call(f_op);
    assign ras_pop     = f_valid && (f_op == OpJr) && (ras_cnt_q != '0);

    // Return-address stack: ring buffer, full push overwrites the oldest slot.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_q[i] <= '0;
            end
        end else if (flush) begin
            ras_cnt_q <= '0;
        end else if (ras_push) begin
            ras_q[ras_ptr_q] <= f_pc + 32'd8;
            ras_ptr_q        <= ras_ptr_inc;
            if (ras_cnt_q != RasCntW'(RAS_DEPTH)) begin
                ras_cnt_q <= ras_cnt_q + 1'b1;
            end
        end else if (ras_pop) begin
            ras_ptr_q <= ras_ptr_dec;
            ras_cnt_q <= ras_cnt_q - 1'b1;
        end
    end
`endif

    // Combinational lookup from the entry flops (pre-write values on a same-cycle train).
    always_comb begin
        hit = f_valid && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        jmp = '0;
        if (f_valid && (is_cond(f_op) || is_uncond(f_op))) begin
            jmp.valid = 1'b1;
            if (is_cond(f_op)) begin
                jmp.en = hit && ctr_q[f_idx][CTR_BITS-1];
            end else begin
                jmp.en = hit;
            end
            if (jmp.en) begin
                jmp.pc_dst = target_q[f_idx];
            end
`ifdef FETCH_BP_RAS_EN
            if (ras_pop) begin
                jmp.en     = 1'b1;
                jmp.pc_dst = ras_q[ras_ptr_dec];
            end
`endif
        end
    end

    // Training decision for the resolved instruction.
    always_comb begin
        wr_en     = 1'b0;
        wr_target = target_q[ex_idx];
        wr_ctr    = ctr_q[ex_idx];
        if (ex_valid) begin
            if (is_uncond(ex_op)) begin
                wr_en     = 1'b1;
                wr_target = ex_target;
                wr_ctr    = CtrMax;
            end else if (is_cond(ex_op)) begin
                if (ex_hit) begin
                    wr_en = 1'b1;
                    if (ex_taken) begin
                        wr_target = ex_target;
                        if (ctr_q[ex_idx] != CtrMax) begin
                            wr_ctr = ctr_q[ex_idx] + 1'b1;
                        end
                    end else if (ctr_q[ex_idx] != '0) begin
                        wr_ctr = ctr_q[ex_idx] - 1'b1;
                    end
                end else if (ex_taken) begin
                    wr_en     = 1'b1;
                    wr_target = ex_target;
                    wr_ctr    = CtrWeak;
                end
            end
        end
    end

    // BTB storage; async reset discards any write in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else if (wr_en) begin
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= wr_target;
            ctr_q[ex_idx]    <= wr_ctr;
        end
    end

endmodule
